draw_sequencer: RTL and testbench



---
 rtl/draw_seq_pkg.sv | 23 ++
 rtl/step_counter.sv | 31 +++
 rtl/draw_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_draw_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_seq_pkg.sv
// draw_seq_pkg: state encodings, default erase colour and packed-bus slice helper for draw_sequencer.
`default_nettype none

package draw_seq_pkg;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD       = 3'd1;
  localparam logic [2:0] S_DRAW       = 3'd2;
  localparam logic [2:0] S_LOGIC      = 3'd3;
  localparam logic [2:0] S_LOGIC_WAIT = 3'd4;
  localparam logic [2:0] S_INC        = 3'd5;
  localparam logic [2:0] S_CHANGE     = 3'd6;

  localparam int DRAW_SEQ_ERASE_COLOUR = 0;

  // Lowest bit index of channel k inside a packed bus of w-bit fields.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/step_counter.sv
// step_counter: free-running slot counter with synchronous clear/enable and a "reached limit-1" flag.
`default_nettype none

module step_counter #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_at_limit
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_at_limit = (r_count == (i_limit - W'(1)));

endmodule

`default_nettype wire

// File: rtl/draw_sequencer.sv
// draw_sequencer: two-pass (erase/colour) frame sequencer and plot mux for NUM_CH draw clients.
// Optional VGA overlay port and frame freeze enabled by defining DRAW_SEQ_OVERLAY_EN.
`default_nettype none

module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int                  NUM_CH       = 3,
  parameter int                  COORD_W      = 10,
  parameter int                  COLOUR_W     = 3,
  parameter int                  TIMEOUT_W    = 20,
  parameter logic [COLOUR_W-1:0] ERASE_COLOUR = COLOUR_W'(DRAW_SEQ_ERASE_COLOUR)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          frame_en,
  output logic [NUM_CH-1:0]             ch_go,
  input  logic [NUM_CH-1:0]             ch_done,
  input  logic [NUM_CH*TIMEOUT_W-1:0]   ch_timeout,
  input  logic [NUM_CH*COORD_W-1:0]     ch_x,
  input  logic [NUM_CH*COORD_W-1:0]     ch_y,
  input  logic [NUM_CH*COLOUR_W-1:0]    ch_colour,
  input  logic [NUM_CH-1:0]             ch_wren,
  output logic                          logic_go,
  input  logic                          logic_done,
  output logic                          inc_enable,
  output logic [COORD_W-1:0]            x,
  output logic [COORD_W-1:0]            y,
  output logic [COLOUR_W-1:0]           colour,
  output logic                          writeEn,
  output logic                          iscolour,
  output logic                          busy,
  output logic                          frame_skipped,
`ifdef DRAW_SEQ_OVERLAY_EN
  input  logic                          overlay_active,
  input  logic [COORD_W-1:0]            overlay_x,
  input  logic [COORD_W-1:0]            overlay_y,
  input  logic [COLOUR_W-1:0]           overlay_colour,
  input  logic                          overlay_en,
`endif
  output logic [NUM_CH-1:0]             timeout_err
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [2:0]           r_state;
  logic [CH_W-1:0]      r_ch;
  logic                 r_iscolour;
  logic [NUM_CH-1:0]    r_timeout_err;

  logic [2:0]           w_state_nxt;
  logic [CH_W-1:0]      w_ch_nxt;
  logic                 w_iscolour_nxt;
  logic [NUM_CH-1:0]    w_timeout_err_nxt;

  logic                 w_freeze;
  logic                 w_any_en;
  logic [CH_W-1:0]      w_first_en;
  logic                 w_has_next;
  logic [CH_W-1:0]      w_next_en;
  logic                 w_done;
  logic                 w_at_limit;
  logic                 w_in_slot;
  logic [TIMEOUT_W-1:0] w_cur_timeout;

`ifdef DRAW_SEQ_OVERLAY_EN
  assign w_freeze = overlay_active;
`else
  assign w_freeze = 1'b0;
`endif

  assign w_cur_timeout = ch_timeout[slice_lo(int'(r_ch), TIMEOUT_W) +: TIMEOUT_W];
  assign w_done        = ch_done[r_ch];
  assign w_in_slot     = (r_state == S_LOAD) || (r_state == S_DRAW);

  // Descending scan so the last hit is the lowest enabled index.
  always_comb begin
    w_any_en   = 1'b0;
    w_first_en = '0;
    w_has_next = 1'b0;
    w_next_en  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_timeout[slice_lo(k, TIMEOUT_W) +: TIMEOUT_W] != '0) begin
        w_any_en   = 1'b1;
        w_first_en = CH_W'(k);
        if (k > int'(r_ch)) begin
          w_has_next = 1'b1;
          w_next_en  = CH_W'(k);
        end
      end
    end
  end

  step_counter #(
    .W (TIMEOUT_W)
  ) u_slot_counter (
    .clk        (clk),
    .resetn     (resetn),
    .i_clr      (r_state == S_LOAD),
    .i_en       ((r_state == S_DRAW) && !w_freeze),
    .i_limit    (w_cur_timeout),
    .o_at_limit (w_at_limit)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_ch_nxt          = r_ch;
    w_iscolour_nxt    = r_iscolour;
    w_timeout_err_nxt = r_timeout_err;
    if (!w_freeze) begin
      case (r_state)
        S_IDLE: begin
          if (frame_en) begin
            if (w_any_en) begin
              w_state_nxt = S_LOAD;
              w_ch_nxt    = w_first_en;
            end else begin
              w_state_nxt = S_LOGIC;
            end
          end
        end
        S_LOAD: w_state_nxt = S_DRAW;
        S_DRAW: begin
          if (w_done || w_at_limit) begin
            // done has priority: a coincident timeout is not an error
            if (!w_done) begin
              w_timeout_err_nxt[r_ch] = 1'b1;
            end
            if (w_has_next) begin
              w_state_nxt = S_LOAD;
              w_ch_nxt    = w_next_en;
            end else if (r_iscolour) begin
              w_state_nxt = S_CHANGE;
            end else begin
              w_state_nxt = S_LOGIC;
            end
          end
        end
        S_LOGIC: w_state_nxt = S_LOGIC_WAIT;
        S_LOGIC_WAIT: begin
          if (logic_done) begin
            w_state_nxt = S_INC;
          end
        end
        S_INC: w_state_nxt = S_CHANGE;
        S_CHANGE: begin
          w_iscolour_nxt = !r_iscolour;
          if (r_iscolour) begin
            w_state_nxt = S_IDLE;
          end else if (w_any_en) begin
            w_state_nxt = S_LOAD;
            w_ch_nxt    = w_first_en;
          end else begin
            // empty colour pass: go straight to the closing CHANGE
            w_state_nxt = S_CHANGE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_ch          <= '0;
      r_iscolour    <= 1'b0;
      r_timeout_err <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ch          <= w_ch_nxt;
      r_iscolour    <= w_iscolour_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  always_comb begin
    ch_go = '0;
    if ((r_state == S_LOAD) && !w_freeze) begin
      ch_go[r_ch] = 1'b1;
    end
  end

  assign logic_go      = (r_state == S_LOGIC) && !w_freeze;
  assign inc_enable    = (r_state == S_INC) && !w_freeze;
  assign busy          = (r_state != S_IDLE);
  assign frame_skipped = frame_en && busy && !w_freeze;
  assign iscolour      = r_iscolour;
  assign timeout_err   = r_timeout_err;

  always_comb begin
    x       = '0;
    y       = '0;
    colour  = '0;
    writeEn = 1'b0;
    if (w_in_slot) begin
      x       = ch_x[slice_lo(int'(r_ch), COORD_W) +: COORD_W];
      y       = ch_y[slice_lo(int'(r_ch), COORD_W) +: COORD_W];
      colour  = r_iscolour ? ch_colour[slice_lo(int'(r_ch), COLOUR_W) +: COLOUR_W] : ERASE_COLOUR;
      writeEn = ch_wren[r_ch];
    end
`ifdef DRAW_SEQ_OVERLAY_EN
    if (overlay_active) begin
      x       = overlay_x;
      y       = overlay_y;
      colour  = overlay_colour;
      writeEn = overlay_en;
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: directed scenario tests for draw_sequencer with auto-responding draw clients.
`default_nettype none

module tb_draw_sequencer;

  localparam int NCH  = 3;
  localparam int CW   = 10;
  localparam int KW   = 3;
  localparam int TW   = 20;
  localparam int MAXC = 200;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                frame_en = 1'b0;
  logic [NCH-1:0]      ch_go;
  logic [NCH-1:0]      ch_done = '0;
  logic [NCH*TW-1:0]   ch_timeout = '0;
  logic [NCH*CW-1:0]   ch_x = '0;
  logic [NCH*CW-1:0]   ch_y = '0;
  logic [NCH*KW-1:0]   ch_colour = '0;
  logic [NCH-1:0]      ch_wren = '0;
  logic                logic_go;
  logic                logic_done = 1'b0;
  logic                inc_enable;
  logic [CW-1:0]       x;
  logic [CW-1:0]       y;
  logic [KW-1:0]       colour;
  logic                writeEn;
  logic                iscolour;
  logic                busy;
  logic                frame_skipped;
  logic [NCH-1:0]      timeout_err;
`ifdef DRAW_SEQ_OVERLAY_EN
  logic                overlay_active = 1'b0;
  logic [CW-1:0]       overlay_x = '0;
  logic [CW-1:0]       overlay_y = '0;
  logic [KW-1:0]       overlay_colour = '0;
  logic                overlay_en = 1'b0;
`endif

  draw_sequencer dut (
    .clk           (clk),
    .resetn        (resetn),
    .frame_en      (frame_en),
    .ch_go         (ch_go),
    .ch_done       (ch_done),
    .ch_timeout    (ch_timeout),
    .ch_x          (ch_x),
    .ch_y          (ch_y),
    .ch_colour     (ch_colour),
    .ch_wren       (ch_wren),
    .logic_go      (logic_go),
    .logic_done    (logic_done),
    .inc_enable    (inc_enable),
    .x             (x),
    .y             (y),
    .colour        (colour),
    .writeEn       (writeEn),
    .iscolour      (iscolour),
    .busy          (busy),
    .frame_skipped (frame_skipped),
`ifdef DRAW_SEQ_OVERLAY_EN
    .overlay_active(overlay_active),
    .overlay_x     (overlay_x),
    .overlay_y     (overlay_y),
    .overlay_colour(overlay_colour),
    .overlay_en    (overlay_en),
`endif
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Client models: ch_done[k] rises dly[k] cycles after ch_go[k] (0 = never).
  int dly[NCH];
  int cnt[NCH];
  int ldly = 5;
  int lcnt = 0;

  always @(negedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (!resetn) begin
        cnt[k] = 0; ch_done[k] = 1'b0;
      end else if (ch_go[k]) begin
        cnt[k] = dly[k]; ch_done[k] = 1'b0;
      end else if (cnt[k] != 0) begin
        cnt[k] = cnt[k] - 1; ch_done[k] = (cnt[k] == 0);
      end else begin
        ch_done[k] = 1'b0;
      end
    end
    if (!resetn) begin
      lcnt = 0; logic_done = 1'b0;
    end else if (logic_go) begin
      lcnt = ldly; logic_done = 1'b0;
    end else if (lcnt != 0) begin
      lcnt = lcnt - 1; logic_done = (lcnt == 0);
    end else begin
      logic_done = 1'b0;
    end
  end

  // Per-cycle frame recording; cycle 1 is the first cycle after the frame_en pulse.
  int            go_ch [MAXC];
  logic          iscol_r [MAXC];
  logic          lgo_r [MAXC];
  logic          inc_r [MAXC];
  logic          wen_r [MAXC];
  logic          fsk_r [MAXC];
  logic [KW-1:0] col_r [MAXC];
  logic [CW-1:0] x_r [MAXC];
  logic [NCH-1:0] te_r [MAXC];
  int            ncyc;
  logic          tog = 1'b0;
  int            skip_cyc = 0;

  task automatic run_frame();
    int g;
    ncyc = MAXC;
    @(negedge clk); frame_en = 1'b1;
    @(negedge clk);
    for (int c = 1; c < MAXC; c++) begin
      frame_en = (c == skip_cyc);
      if (tog) ch_wren[2:1] = ~ch_wren[2:1];
      #1;
      if (!busy) begin
        ncyc = c - 1;
        break;
      end
      g = -1;
      for (int k = NCH - 1; k >= 0; k--) if (ch_go[k]) g = k;
      if ($countones(ch_go) > 1) g = -2;
      go_ch[c] = g; iscol_r[c] = iscolour; lgo_r[c] = logic_go; inc_r[c] = inc_enable;
      wen_r[c] = writeEn; fsk_r[c] = frame_skipped; col_r[c] = colour; x_r[c] = x;
      te_r[c] = timeout_err;
      @(negedge clk);
    end
    frame_en = 1'b0;
  endtask

  task automatic std_config();
    ch_timeout = {20'd8, 20'd8, 20'd8};
    for (int k = 0; k < NCH; k++) dly[k] = 3;
    ldly = 5; tog = 1'b0; skip_cyc = 0;
    ch_x = {10'd102, 10'd101, 10'd100};
    ch_y = {10'd202, 10'd201, 10'd200};
    ch_colour = {3'b110, 3'b011, 3'b101};
    ch_wren = 3'b001;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0 || ch_go !== 3'b000 || writeEn !== 1'b0) $display("FAIL reset_ctrl: busy=%b ch_go=%b writeEn=%b, expected 0/000/0", busy, ch_go, writeEn); else n_pass++;
    n_checks++; if (iscolour !== 1'b0 || timeout_err !== 3'b000 || x !== '0 || colour !== '0) $display("FAIL reset_out: iscolour=%b timeout_err=%b x=%0d colour=%0d, expected all 0", iscolour, timeout_err, x, colour); else n_pass++;
    @(negedge clk); resetn = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || logic_go !== 1'b0 || inc_enable !== 1'b0 || frame_skipped !== 1'b0) $display("FAIL post_reset_idle: busy=%b logic_go=%b inc=%b fskip=%b, expected 0", busy, logic_go, inc_enable, frame_skipped); else n_pass++;
  endtask

  task automatic test_frame_flow();
    int exp_c[6];
    int exp_k[6];
    int n;
    int nl;
    int lc;
    int ni;
    int ic;
    exp_c = '{1, 5, 9, 21, 25, 29};
    exp_k = '{0, 1, 2, 0, 1, 2};
    std_config();
    run_frame();
    n_checks++; if (ncyc !== 33) $display("FAIL frame_len: got %0d cycles, expected 33", ncyc); else n_pass++;
    n = 0; nl = 0; lc = 0; ni = 0; ic = 0;
    for (int c = 1; c <= ncyc && c < MAXC; c++) begin
      if (go_ch[c] != -1) begin
        n_checks++;
        if (n >= 6 || c !== exp_c[n] || go_ch[c] !== exp_k[n] || iscol_r[c] !== (n >= 3))
          $display("FAIL go_order[%0d]: got ch%0d at cycle %0d iscolour=%b", n, go_ch[c], c, iscol_r[c]);
        else n_pass++;
        n++;
      end
      if (lgo_r[c]) begin nl++; lc = c; end
      if (inc_r[c]) begin ni++; ic = c; end
    end
    n_checks++; if (n !== 6) $display("FAIL go_count: got %0d, expected 6", n); else n_pass++;
    n_checks++; if (nl !== 1 || lc !== 13) $display("FAIL logic_go: got %0d pulses last at %0d, expected 1 at 13", nl, lc); else n_pass++;
    n_checks++; if (ni !== 1 || ic !== 19) $display("FAIL inc_enable: got %0d pulses last at %0d, expected 1 at 19", ni, ic); else n_pass++;
    n_checks++; if (iscol_r[20] !== 1'b0 || iscol_r[21] !== 1'b1) $display("FAIL iscolour_rise: got %b->%b, expected 0->1", iscol_r[20], iscol_r[21]); else n_pass++;
    n_checks++; if (iscolour !== 1'b0 || busy !== 1'b0) $display("FAIL frame_end: iscolour=%b busy=%b, expected 0/0", iscolour, busy); else n_pass++;
  endtask

  task automatic test_mux_colour();
    std_config();
    tog = 1'b1;
    run_frame();
    n_checks++; if (col_r[2] !== 3'b000 || wen_r[2] !== 1'b1 || x_r[2] !== 10'd100) $display("FAIL mux_erase_ch0: colour=%b wen=%b x=%0d, expected 000/1/100", col_r[2], wen_r[2], x_r[2]); else n_pass++;
    n_checks++; if (col_r[6] !== 3'b000 || x_r[6] !== 10'd101) $display("FAIL mux_erase_ch1: colour=%b x=%0d, expected 000/101", col_r[6], x_r[6]); else n_pass++;
    n_checks++; if (wen_r[16] !== 1'b0 || x_r[16] !== '0 || col_r[16] !== '0) $display("FAIL mux_idle_slot: wen=%b x=%0d colour=%b, expected 0/0/000", wen_r[16], x_r[16], col_r[16]); else n_pass++;
    n_checks++; if (col_r[22] !== 3'b101 || wen_r[22] !== 1'b1 || x_r[22] !== 10'd100) $display("FAIL mux_colour_ch0: colour=%b wen=%b x=%0d, expected 101/1/100", col_r[22], wen_r[22], x_r[22]); else n_pass++;
    n_checks++; if (col_r[26] !== 3'b011) $display("FAIL mux_colour_ch1: colour=%b, expected 011", col_r[26]); else n_pass++;
    tog = 1'b0;
  endtask

  task automatic test_timeout();
    int n1;
    std_config();
    ch_timeout = {20'd8, 20'd10, 20'd8};
    dly[1] = 0;
    run_frame();
    n1 = 0;
    for (int c = 6; c <= 15; c++) if (go_ch[c] != -1) n1++;
    n_checks++; if (go_ch[5] !== 1 || n1 !== 0 || go_ch[16] !== 2) $display("FAIL timeout_len: go@5=%0d go@16=%0d gos_between=%0d, expected 1/2/0", go_ch[5], go_ch[16], n1); else n_pass++;
    n_checks++; if (te_r[15] !== 3'b000 || te_r[16] !== 3'b010) $display("FAIL timeout_err_set: got %b->%b, expected 000->010", te_r[15], te_r[16]); else n_pass++;
    n_checks++; if (ncyc !== 47) $display("FAIL timeout_frame_len: got %0d, expected 47", ncyc); else n_pass++;
    n_checks++; if (timeout_err !== 3'b010) $display("FAIL timeout_err_sticky: got %b, expected 010", timeout_err); else n_pass++;
  endtask

  task automatic test_reset_mid_draw();
    std_config();
    @(negedge clk); frame_en = 1'b1;
    @(negedge clk); frame_en = 1'b0;
    repeat (21) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b1 || writeEn !== 1'b1 || iscolour !== 1'b1 || timeout_err !== 3'b010 || x !== 10'd100) $display("FAIL pre_reset: busy=%b wen=%b iscolour=%b terr=%b x=%0d, expected 1/1/1/010/100", busy, writeEn, iscolour, timeout_err, x); else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || writeEn !== 1'b0 || iscolour !== 1'b0 || timeout_err !== 3'b000 || ch_go !== 3'b000) $display("FAIL async_reset: busy=%b wen=%b iscolour=%b terr=%b ch_go=%b, expected all 0", busy, writeEn, iscolour, timeout_err, ch_go); else n_pass++;
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_disabled_channel();
    int n1;
    std_config();
    ch_timeout = {20'd8, 20'd0, 20'd8};
    run_frame();
    n1 = 0;
    for (int c = 1; c <= ncyc && c < MAXC; c++) if (go_ch[c] == 1) n1++;
    n_checks++; if (n1 !== 0) $display("FAIL disabled_go: ch1 got %0d go pulses, expected 0", n1); else n_pass++;
    n_checks++; if (go_ch[5] !== 2 || iscol_r[5] !== 1'b0 || go_ch[21] !== 2 || iscol_r[21] !== 1'b1) $display("FAIL disabled_skip: go@5=%0d go@21=%0d, expected 2/2", go_ch[5], go_ch[21]); else n_pass++;
    n_checks++; if (ncyc !== 25) $display("FAIL disabled_len: got %0d, expected 25", ncyc); else n_pass++;
  endtask

  task automatic test_busy_skip();
    int nf;
    std_config();
    skip_cyc = 15;
    run_frame();
    skip_cyc = 0;
    nf = 0;
    for (int c = 1; c <= ncyc && c < MAXC; c++) if (fsk_r[c]) nf++;
    n_checks++; if (fsk_r[15] !== 1'b1 || nf !== 1) $display("FAIL frame_skipped: at15=%b pulses=%0d, expected 1/1", fsk_r[15], nf); else n_pass++;
    n_checks++; if (ncyc !== 33) $display("FAIL skip_no_restart_len: got %0d, expected 33", ncyc); else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL skip_no_restart: busy=%b, expected 0", busy); else n_pass++;
  endtask

`ifdef DRAW_SEQ_OVERLAY_EN
  task automatic test_overlay();
    int bad;
    int go1;
    std_config();
    dly[0] = 0;
    @(negedge clk); frame_en = 1'b1;
    @(negedge clk); frame_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    overlay_active = 1'b1; overlay_x = 10'd7; overlay_y = 10'd9; overlay_colour = 3'b010; overlay_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (x !== 10'd7 || y !== 10'd9 || colour !== 3'b010 || writeEn !== 1'b1 || ch_go !== 3'b000 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad !== 0) $display("FAIL overlay_mirror: got %0d bad cycles, expected 0", bad); else n_pass++;
    overlay_active = 1'b0;
    go1 = 0;
    for (int c = 23; c < 60; c++) begin
      #1;
      if (ch_go[1] && go1 == 0) go1 = c;
      @(negedge clk);
    end
    n_checks++; if (go1 !== 30) $display("FAIL overlay_resume: ch1 go at %0d, expected 30", go1); else n_pass++;
    for (int i = 0; i < MAXC && busy; i++) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL overlay_frame_end: busy=%b, expected 0", busy); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_frame_flow();
    test_mux_colour();
    test_timeout();
    test_reset_mid_draw();
    test_disabled_channel();
    test_busy_skip();
`ifdef DRAW_SEQ_OVERLAY_EN
    test_overlay();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks", n_pass, n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
